// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared definitions for the data-memory arbiter: burst FSM
//               state encoding and the word stride used for burst addressing.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_BURST = ST_BURST,
    S_DONE  = ST_DONE
  } state_t;

  // Bytes per data word; burst addresses advance by this amount per beat.
  localparam int unsigned WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the CPU MEM-stage port, the DMA burst port and the
//               data-memory port of the arbiter.
// Modports    : slave  - arbiter view (CPU/DMA/memory-read-data inputs,
//                        grant/handshake/memory-command outputs)
//               master - environment view (the reverse directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  // CPU side
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // DMA side
  logic              dma_req_valid;
  logic              dma_req_ready;
  logic              dma_req_write;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [LEN_W-1:0]  dma_req_len;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_wdata_ready;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rdata_valid;
  logic              dma_done;
  // Memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
           dma_req_valid, dma_req_write, dma_req_addr, dma_req_len, dma_wdata,
           mem_rdata,
    output cpu_rdata, cpu_stall, dma_req_ready, dma_wdata_ready, dma_rdata,
           dma_rdata_valid, dma_done, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
           dma_req_valid, dma_req_write, dma_req_addr, dma_req_len, dma_wdata,
           mem_rdata,
    input  cpu_rdata, cpu_stall, dma_req_ready, dma_wdata_ready, dma_rdata,
           dma_rdata_valid, dma_done, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmem_burst_ctr
// Description : Holds the current burst word address and the remaining beat
//               count. Load captures a new burst (address word-aligned),
//               step advances one beat.
// Ports       : clk, reset (async, active-low)
//               i_load/i_addr/i_len - start a burst
//               i_step              - one beat completes this cycle
//               o_addr              - address of the current beat
//               o_last              - current beat is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_burst_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_load,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic [LEN_W-1:0]  i_len,
  input  wire logic              i_step,
  output logic      [ADDR_W-1:0] o_addr,
  output logic                   o_last
);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_addr & c_ALIGN_MASK;
      r_remaining <= i_len;
    end else if (i_step) begin
      // Address wraps naturally modulo 2^ADDR_W.
      r_addr      <= r_addr + ADDR_W'(WORD_BYTES);
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one data-memory port between the pipeline MEM stage
//               (priority) and a DMA burst requester. A wait counter bounds
//               DMA starvation by forcing a DMA beat (and stalling the CPU)
//               after MAX_WAIT consecutive CPU grants during a burst.
// Ports       : clk, reset (async, active-low)
//               bus (dmem_arbiter_if.slave) - CPU, DMA and memory signals
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int MAX_WAIT = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  dmem_arbiter_if.slave  bus
);
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              r_is_write, w_is_write_nxt;
  logic              w_load, w_step, w_last;
  logic              w_cpu_req, w_dma_beat;
  logic [ADDR_W-1:0] w_cur_addr;

  dmem_burst_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_ctr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_addr (bus.dma_req_addr),
    .i_len  (bus.dma_req_len),
    .i_step (w_step),
    .o_addr (w_cur_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      r_is_write <= w_is_write_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_wait_nxt          = r_wait;
    w_is_write_nxt      = r_is_write;
    w_load              = 1'b0;
    w_step              = 1'b0;
    w_cpu_req           = bus.cpu_mem_read | bus.cpu_mem_write;
    w_dma_beat          = 1'b0;
    bus.cpu_rdata       = DATA_W'(0);
    bus.cpu_stall       = 1'b0;
    bus.dma_req_ready   = 1'b0;
    bus.dma_wdata_ready = 1'b0;
    bus.dma_rdata       = DATA_W'(0);
    bus.dma_rdata_valid = 1'b0;
    bus.dma_done        = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_addr        = ADDR_W'(0);
    bus.mem_wdata       = DATA_W'(0);

    // Outputs are forced low for the whole time reset is held, including the
    // combinational CPU pass-through path.
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          bus.dma_req_ready = 1'b1;
          if (bus.dma_req_valid) begin
            w_load         = 1'b1;
            w_is_write_nxt = bus.dma_req_write;
            w_wait_nxt     = '0;
            w_state_nxt    = (bus.dma_req_len == '0) ? S_DONE : S_BURST;
          end
        end
        S_BURST: begin
          if (w_cpu_req && (r_wait < c_MAX_WAIT)) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
          end else begin
            w_dma_beat = 1'b1;
            w_step     = 1'b1;
            w_wait_nxt = '0;
            if (w_last) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          bus.dma_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      if (w_dma_beat) begin
        // A displaced CPU access must be held and re-presented next cycle.
        bus.cpu_stall = w_cpu_req;
        bus.mem_addr  = w_cur_addr;
        if (r_is_write) begin
          bus.mem_write       = 1'b1;
          bus.mem_wdata       = bus.dma_wdata;
          bus.dma_wdata_ready = 1'b1;
        end else begin
          bus.mem_read        = 1'b1;
          bus.dma_rdata       = bus.mem_rdata;
          bus.dma_rdata_valid = 1'b1;
        end
      end else begin
        bus.mem_read  = bus.cpu_mem_read;
        bus.mem_write = bus.cpu_mem_write;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_rdata = bus.cpu_mem_read ? bus.mem_rdata : DATA_W'(0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Two instances share the
//               same stimulus: u_a with MAX_WAIT = 4 and u_b with MAX_WAIT = 0.
//               Directed scenarios check fixed expected sequences; a random
//               phase compares every output against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MW_A = 4;
  localparam int MW_B = 0;

  typedef struct packed {
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req_ready;
    logic        dma_wdata_ready;
    logic [31:0] dma_rdata;
    logic        dma_rdata_valid;
    logic        dma_done;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } outs_t;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dma_valid, dma_write;
  logic [31:0] dma_addr, dma_wdata;
  logic [7:0]  dma_len;
  logic [31:0] mrd;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) ifa ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) ifb ();

  assign ifa.cpu_mem_read  = cpu_rd;    assign ifb.cpu_mem_read  = cpu_rd;
  assign ifa.cpu_mem_write = cpu_wr;    assign ifb.cpu_mem_write = cpu_wr;
  assign ifa.cpu_addr      = cpu_addr;  assign ifb.cpu_addr      = cpu_addr;
  assign ifa.cpu_wdata     = cpu_wdata; assign ifb.cpu_wdata     = cpu_wdata;
  assign ifa.dma_req_valid = dma_valid; assign ifb.dma_req_valid = dma_valid;
  assign ifa.dma_req_write = dma_write; assign ifb.dma_req_write = dma_write;
  assign ifa.dma_req_addr  = dma_addr;  assign ifb.dma_req_addr  = dma_addr;
  assign ifa.dma_req_len   = dma_len;   assign ifb.dma_req_len   = dma_len;
  assign ifa.dma_wdata     = dma_wdata; assign ifb.dma_wdata     = dma_wdata;
  assign ifa.mem_rdata     = mrd;       assign ifb.mem_rdata     = mrd;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .MAX_WAIT(MW_A)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .MAX_WAIT(MW_B)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- transaction-level reference model ----------------
  // Per instance: is a burst in flight, which word it is at, how many words
  // are still owed, how many CPU grants in a row it has conceded, and
  // whether the completion pulse is due this cycle.
  bit          m_busy   [2];
  bit          m_done   [2];
  bit          m_wr     [2];
  logic [31:0] m_addr   [2];
  int          m_left   [2];
  int          m_streak [2];

  function automatic int mw(input int k);
    return (k == 0) ? MW_A : MW_B;
  endfunction

  function automatic bit m_beat(input int k);
    bit req = cpu_rd | cpu_wr;
    return m_busy[k] && !(req && (m_streak[k] < mw(k)));
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_wr[k] <= 1'b0;
        m_addr[k] <= '0;   m_left[k] <= 0;    m_streak[k] <= 0;
      end else if (m_done[k]) begin
        m_done[k] <= 1'b0;
      end else if (!m_busy[k]) begin
        if (dma_valid) begin
          m_addr[k]   <= dma_addr & ~32'h3;
          m_left[k]   <= int'(dma_len);
          m_wr[k]     <= dma_write;
          m_streak[k] <= 0;
          if (dma_len == 8'd0) m_done[k] <= 1'b1;
          else                 m_busy[k] <= 1'b1;
        end
      end else if (m_beat(k)) begin
        m_addr[k]   <= m_addr[k] + 32'd4;
        m_left[k]   <= m_left[k] - 1;
        m_streak[k] <= 0;
        if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
        end
      end else begin
        m_streak[k] <= m_streak[k] + 1;
      end
    end
  end

  function automatic outs_t exp_out(input int k);
    outs_t o = '0;
    if (!reset) return o;
    o.dma_req_ready = !m_busy[k] && !m_done[k];
    o.dma_done      = m_done[k];
    if (m_beat(k)) begin
      o.cpu_stall = cpu_rd | cpu_wr;
      o.mem_addr  = m_addr[k];
      if (m_wr[k]) begin
        o.mem_write = 1'b1; o.mem_wdata = dma_wdata; o.dma_wdata_ready = 1'b1;
      end else begin
        o.mem_read = 1'b1; o.dma_rdata = mrd; o.dma_rdata_valid = 1'b1;
      end
    end else begin
      o.mem_read  = cpu_rd;
      o.mem_write = cpu_wr;
      o.mem_addr  = cpu_addr;
      o.mem_wdata = cpu_wdata;
      o.cpu_rdata = cpu_rd ? mrd : 32'h0;
    end
    return o;
  endfunction

  function automatic outs_t act_out(input int k);
    outs_t o;
    if (k == 0)
      o = {ifa.cpu_rdata, ifa.cpu_stall, ifa.dma_req_ready, ifa.dma_wdata_ready,
           ifa.dma_rdata, ifa.dma_rdata_valid, ifa.dma_done, ifa.mem_read,
           ifa.mem_write, ifa.mem_addr, ifa.mem_wdata};
    else
      o = {ifb.cpu_rdata, ifb.cpu_stall, ifb.dma_req_ready, ifb.dma_wdata_ready,
           ifb.dma_rdata, ifb.dma_rdata_valid, ifb.dma_done, ifb.mem_read,
           ifb.mem_write, ifb.mem_addr, ifb.mem_wdata};
    return o;
  endfunction

  // ---------------- stimulus utilities ----------------
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_valid = 0; dma_write = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    mrd = '0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      drv(); idle_inputs(); @(negedge clk);
      ok = (ifa.dma_req_ready === 1'b1) && (ifb.dma_req_ready === 1'b1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: ready a=%b b=%b, required 1 1 within 50 cycles",
               ifa.dma_req_ready, ifb.dma_req_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      drv();
      cpu_rd = 1'($urandom); cpu_wr = 1'($urandom); cpu_addr = $urandom;
      cpu_wdata = $urandom; dma_valid = 1'($urandom); dma_write = 1'($urandom);
      dma_addr = $urandom; dma_len = 8'($urandom); dma_wdata = $urandom; mrd = $urandom;
      @(negedge clk);
      checks++;
      if (act_out(0) !== '0 || act_out(1) !== '0) begin
        errors++;
        $display("FAIL reset_outputs_zero: a=%h b=%h, required all 0", act_out(0), act_out(1));
      end
    end
    drv(); idle_inputs(); reset = 1; @(negedge clk);
    checks++;
    if ({ifa.dma_req_ready, ifa.mem_read, ifa.mem_write, ifa.mem_addr, ifa.mem_wdata} !== {1'b1, 66'b0} ||
        {ifb.dma_req_ready, ifb.mem_read, ifb.mem_write, ifb.mem_addr, ifb.mem_wdata} !== {1'b1, 66'b0}) begin
      errors++;
      $display("FAIL reset_release_idle: ready a=%b b=%b mem_addr a=%h, required ready 1 mem 0",
               ifa.dma_req_ready, ifb.dma_req_ready, ifa.mem_addr);
    end
  endtask

  task automatic test_read_burst();
    wait_idle();
    drv(); dma_valid = 1; dma_write = 0; dma_addr = 32'h13; dma_len = 8'd3; @(negedge clk);
    checks++;
    if (ifa.dma_req_ready !== 1'b1) begin
      errors++; $display("FAIL read_accept: ready=%b, required 1", ifa.dma_req_ready);
    end
    for (int j = 0; j < 3; j++) begin
      drv(); dma_valid = 0; mrd = 32'h1111_0000 + 32'(j); @(negedge clk);
      checks++;
      if ({ifa.dma_rdata_valid, ifa.mem_read, ifa.dma_done} !== 3'b110 ||
          ifa.mem_addr !== 32'(32'h10 + 4 * j) || ifa.dma_rdata !== mrd) begin
        errors++;
        $display("FAIL read_beat%0d: valid=%b addr=%h rdata=%h, required 1 %h %h",
                 j, ifa.dma_rdata_valid, ifa.mem_addr, ifa.dma_rdata, 32'(32'h10 + 4 * j), mrd);
      end
    end
    drv(); @(negedge clk);
    checks++;
    if ({ifa.dma_done, ifa.dma_rdata_valid, ifa.mem_read} !== 3'b100) begin
      errors++;
      $display("FAIL read_done: done=%b valid=%b mem_read=%b, required 1 0 0",
               ifa.dma_done, ifa.dma_rdata_valid, ifa.mem_read);
    end
    drv(); @(negedge clk);
    checks++;
    if ({ifa.dma_req_ready, ifa.dma_done} !== 2'b10) begin
      errors++;
      $display("FAIL read_back_idle: ready=%b done=%b, required 1 0", ifa.dma_req_ready, ifa.dma_done);
    end
  endtask

  task automatic test_write_stall();
    bit beat;
    logic [31:0] ea;
    wait_idle();
    drv(); cpu_rd = 1; cpu_addr = 32'h8; cpu_wdata = 32'h5555_AAAA;
    dma_valid = 1; dma_write = 1; dma_addr = 32'h40; dma_len = 8'd2; mrd = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if ({ifa.dma_req_ready, ifa.mem_read, ifa.cpu_stall} !== 3'b110 || ifa.mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL wr_accept: ready=%b mem_read=%b stall=%b addr=%h, required 1 1 0 00000008",
               ifa.dma_req_ready, ifa.mem_read, ifa.cpu_stall, ifa.mem_addr);
    end
    for (int j = 0; j <= 10; j++) begin
      drv(); dma_valid = 0; dma_wdata = 32'hD000_0000 + 32'(j); mrd = $urandom; @(negedge clk);
      beat = (j == 4) || (j == 9);
      ea   = beat ? ((j == 4) ? 32'h40 : 32'h44) : 32'h8;
      checks++;
      if ({ifa.mem_write, ifa.dma_wdata_ready, ifa.cpu_stall, ifa.mem_read, ifa.dma_done} !==
            {beat, beat, beat, !beat, (j == 10)} || ifa.mem_addr !== ea ||
          ifa.mem_wdata !== (beat ? dma_wdata : cpu_wdata) ||
          ifa.cpu_rdata !== (beat ? 32'h0 : mrd)) begin
        errors++;
        $display("FAIL wr_stall_cycle%0d: w/rdy/stall/r/done=%b%b%b%b%b addr=%h, required %b%b%b%b%b %h",
                 j, ifa.mem_write, ifa.dma_wdata_ready, ifa.cpu_stall, ifa.mem_read, ifa.dma_done,
                 ifa.mem_addr, beat, beat, beat, !beat, (j == 10), ea);
      end
    end
  endtask

  task automatic test_maxwait0();
    bit beat;
    wait_idle();
    drv(); cpu_rd = 1; cpu_addr = 32'h20;
    dma_valid = 1; dma_write = 0; dma_addr = 32'h100; dma_len = 8'd4; mrd = 32'h7777_0000;
    @(negedge clk);
    checks++;
    if ({ifb.dma_req_ready, ifb.cpu_stall, ifb.mem_read} !== 3'b101) begin
      errors++;
      $display("FAIL mw0_accept: ready=%b stall=%b mem_read=%b, required 1 0 1",
               ifb.dma_req_ready, ifb.cpu_stall, ifb.mem_read);
    end
    for (int j = 0; j <= 4; j++) begin
      drv(); dma_valid = 0; mrd = 32'h2222_0000 + 32'(j); @(negedge clk);
      beat = (j < 4);
      checks++;
      if ({ifb.dma_rdata_valid, ifb.cpu_stall, ifb.mem_read, ifb.dma_done} !== {beat, beat, 1'b1, !beat} ||
          ifb.mem_addr !== (beat ? 32'(32'h100 + 4 * j) : 32'h20) ||
          ifb.cpu_rdata !== (beat ? 32'h0 : mrd) || ifb.dma_rdata !== (beat ? mrd : 32'h0)) begin
        errors++;
        $display("FAIL mw0_cycle%0d: valid/stall/r/done=%b%b%b%b addr=%h cpu_rdata=%h, required %b%b1%b",
                 j, ifb.dma_rdata_valid, ifb.cpu_stall, ifb.mem_read, ifb.dma_done,
                 ifb.mem_addr, ifb.cpu_rdata, beat, beat, !beat);
      end
    end
  endtask

  task automatic test_len0();
    wait_idle();
    drv(); dma_valid = 1; dma_write = 1; dma_addr = 32'h200; dma_len = 8'd0; @(negedge clk);
    checks++;
    if ({ifa.dma_req_ready, ifa.mem_read, ifa.mem_write} !== 3'b100) begin
      errors++;
      $display("FAIL len0_accept: ready/r/w=%b%b%b, required 100", ifa.dma_req_ready, ifa.mem_read, ifa.mem_write);
    end
    drv(); dma_valid = 0; @(negedge clk);
    checks++;
    if ({ifa.dma_done, ifa.dma_req_ready, ifa.mem_read, ifa.mem_write} !== 4'b1000) begin
      errors++;
      $display("FAIL len0_done: done/ready/r/w=%b%b%b%b, required 1000",
               ifa.dma_done, ifa.dma_req_ready, ifa.mem_read, ifa.mem_write);
    end
    drv(); @(negedge clk);
    checks++;
    if ({ifa.dma_done, ifa.dma_req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL len0_idle: done/ready=%b%b, required 01", ifa.dma_done, ifa.dma_req_ready);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [2];
    ea[0] = 32'hFFFF_FFFC; ea[1] = 32'h0000_0000;
    wait_idle();
    drv(); dma_valid = 1; dma_write = 1; dma_addr = 32'hFFFF_FFFC; dma_len = 8'd2; @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      drv(); dma_valid = 0; dma_wdata = 32'hEEEE_0000 + 32'(j); @(negedge clk);
      checks++;
      if (ifa.mem_write !== 1'b1 || ifa.mem_addr !== ea[j] || ifa.mem_wdata !== dma_wdata) begin
        errors++;
        $display("FAIL wrap_beat%0d: mem_write=%b addr=%h, required 1 %h", j, ifa.mem_write, ifa.mem_addr, ea[j]);
      end
    end
    drv(); @(negedge clk);
    checks++;
    if (ifa.dma_done !== 1'b1) begin
      errors++; $display("FAIL wrap_done: done=%b, required 1", ifa.dma_done);
    end
  endtask

  task automatic test_abort();
    wait_idle();
    drv(); dma_valid = 1; dma_write = 0; dma_addr = 32'h300; dma_len = 8'd5; @(negedge clk);
    drv(); dma_valid = 0; mrd = 32'h3333_0000; @(negedge clk);
    checks++;
    if (ifa.dma_rdata_valid !== 1'b1 || ifa.mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL abort_beat1: valid=%b addr=%h, required 1 00000300", ifa.dma_rdata_valid, ifa.mem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      drv(); reset = 0; @(negedge clk);
      checks++;
      if (act_out(0) !== '0) begin
        errors++; $display("FAIL abort_in_reset%0d: a=%h, required all 0", i, act_out(0));
      end
    end
    drv(); reset = 1; @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drv(); @(negedge clk);
      checks++;
      if ({ifa.dma_done, ifa.mem_read, ifa.dma_rdata_valid, ifa.dma_req_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL abort_after%0d: done/r/valid/ready=%b%b%b%b, required 0001",
                 i, ifa.dma_done, ifa.mem_read, ifa.dma_rdata_valid, ifa.dma_req_ready);
      end
    end
  endtask

  task automatic test_random();
    int r;
    outs_t a, e;
    for (int c = 0; c < 800; c++) begin
      drv();
      reset = ($urandom_range(0, 79) != 0);
      r = int'($urandom_range(0, 7));
      cpu_rd = (r < 3) || (r == 5);
      cpu_wr = (r == 3) || (r == 4) || (r == 5);
      cpu_addr = $urandom; cpu_wdata = $urandom;
      dma_valid = ($urandom_range(0, 3) == 0);
      dma_write = 1'($urandom);
      dma_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      dma_len = 8'($urandom_range(0, 5));
      dma_wdata = $urandom; mrd = $urandom;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        a = act_out(k);
        e = exp_out(k);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL random_dut%0d_cycle%0d: got %h, required %h", k, c, a, e);
        end
      end
    end
    drv(); reset = 1; idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_read_burst();
    test_write_stall();
    test_maxwait0();
    test_len0();
    test_wrap();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between the pipeline MEM stage and the data memory, and shares the single memory port with a DMA/loader requester.
- The DMA side issues word bursts through a valid/ready request handshake. The arbiter sequences the burst addresses itself.
- The CPU has priority. A wait counter bounds DMA starvation; when the bound is hit, the CPU is stalled for one cycle.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width
- LEN_W, 8, burst length field width in words
- MAX_WAIT, 4, consecutive CPU-granted cycles allowed during a burst before DMA is forced a beat; 0 means DMA always wins during a burst

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_mem_read  in  1  MEM stage load
- cpu_mem_write  in  1  MEM stage store
- cpu_addr  in  ADDR_W  MEM stage byte address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, 0 when CPU not granted
- cpu_stall  out  1  hold MEM stage and re-present the same request next cycle
- dma_req_valid  in  1  burst request valid
- dma_req_ready  out  1  arbiter can accept a burst
- dma_req_write  in  1  1 = write burst, 0 = read burst
- dma_req_addr  in  ADDR_W  burst start byte address
- dma_req_len  in  LEN_W  burst length in words
- dma_wdata  in  DATA_W  current write beat data
- dma_wdata_ready  out  1  write beat consumed this cycle
- dma_rdata  out  DATA_W  read beat data
- dma_rdata_valid  out  1  dma_rdata valid this cycle
- dma_done  out  1  one-cycle pulse at burst completion
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_rdata  in  DATA_W  memory read data, combinational

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; cur_addr, remaining, wait_cnt, is_write all cleared to 0.
  - While reset is low, every output is 0, including dma_req_ready.
- States: IDLE, BURST, DONE.
- IDLE:
  - dma_req_ready = 1.
  - On dma_req_valid & dma_req_ready: capture addr with bits [1:0] forced to 0, capture len and write flag, clear wait_cnt.
  - If len = 0, go to DONE (no memory access). Otherwise go to BURST.
  - The CPU always owns memory in IDLE.
- BURST:
  - dma_req_ready = 0.
  - cpu_req = cpu_mem_read | cpu_mem_write.
  - If cpu_req & wait_cnt < MAX_WAIT: CPU granted, wait_cnt += 1 (saturating), no DMA beat.
  - Otherwise: DMA beat. wait_cnt = 0, and cpu_stall = cpu_req.
- DMA write beat (same cycle, combinational):
  - mem_write = 1, mem_addr = cur_addr, mem_wdata = dma_wdata, dma_wdata_ready = 1.
- DMA read beat (same cycle, combinational):
  - mem_read = 1, mem_addr = cur_addr, dma_rdata = mem_rdata, dma_rdata_valid = 1.
- After each beat:
  - cur_addr += 4, wrapping modulo 2^ADDR_W.
  - remaining -= 1.
  - When the beat completes with remaining = 1, go to DONE.
- DONE:
  - dma_done = 1 for exactly one cycle, then go to IDLE.
  - The CPU owns memory.
  - A new request is not accepted in DONE.
- CPU grant, in any state:
  - mem_read, mem_write, mem_addr and mem_wdata pass through from the cpu_* inputs.
  - cpu_rdata = mem_rdata when cpu_mem_read, else 0.
- When no one is granted: mem_read = mem_write = 0, mem_addr = mem_wdata = 0, dma_rdata = 0.
- Stall: cpu_stall is combinational and asserted only in a DMA-beat cycle with a pending CPU request. The next cycle wait_cnt = 0, so the re-presented CPU access is granted whenever MAX_WAIT ≥ 1.
- Simultaneous cpu_mem_read and cpu_mem_write are forwarded unchanged; the arbiter does not resolve them.
- Reset mid-burst: the burst is abandoned, with no dma_done and no further beats.
- dma_req_valid while not in IDLE: ignored; the requester holds it until ready.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2)
  - word-stride constant WORD_BYTES = 4
- One sub-module is natural: dmem_burst_ctr, holding cur_addr and remaining. Its interface is load, step and last. The FSM and grant mux stay in the top module.

Test Plan:
- Reset low with random inputs: all outputs 0. Reset released with the bus idle: dma_req_ready = 1, mem_* = 0.
- Read burst, addr 0x00000013, len 3, CPU idle:
  - dma_rdata_valid on 3 consecutive cycles at mem_addr 0x10, 0x14, 0x18.
  - dma_done one cycle after the third beat.
- Write burst, addr 0x40, len 2, with cpu_mem_read held high at addr 0x8 and MAX_WAIT = 4:
  - 4 CPU-granted cycles, then the DMA beat at 0x40 with cpu_stall = 1, then 1 CPU cycle.
  - Sequence repeats until the second beat at 0x44; then dma_done.
- MAX_WAIT = 0, len 4, CPU load every cycle:
  - 4 back-to-back DMA beats, each with cpu_stall = 1.
  - cpu_rdata = 0 during the beats; the CPU load completes in the DONE cycle.
- len 0 request: accepted, no mem_read/mem_write pulses, dma_done one cycle later, IDLE the cycle after.
- Wrap and abort:
  - Burst at 0xFFFFFFFC, len 2: beats at 0xFFFFFFFC then 0x00000000.
  - Separate run: reset asserted after beat 1 of a len-5 burst. No dma_done, and dma_req_ready = 1 one cycle after reset is released.
